// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between several masters.
// Granted master IDs are queued so in-order responses route back correctly.
module obi_rr_arbiter #(
  parameter int MASTERS     = 3,
  parameter int OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [MASTERS-1:0]    m_req_i,
  output logic [MASTERS-1:0]    m_gnt_o,
  input  logic [MASTERS-1:0]    m_we_i,
  input  logic [MASTERS*4-1:0]  m_be_i,
  input  logic [MASTERS*32-1:0] m_addr_i,
  input  logic [MASTERS*32-1:0] m_wdata_i,
  output logic [MASTERS-1:0]    m_rvalid_o,
  output logic [31:0]           m_rdata_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wdata_o,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_rdata_i,
  output logic                  err_o
);

  localparam int IDW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW  = $clog2(OUTSTANDING + 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] held_id_q, held_id_d;
  logic [IDW-1:0] fifo_q [OUTSTANDING];
  logic [IDW-1:0] fifo_d [OUTSTANDING];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [IDW:0]   rr_sum;
  logic [IDW-1:0] rr_winner;
  logic           rr_found;
  logic [IDW-1:0] winner;
  logic           win_req;
  logic           fifo_full;
  logic           fifo_empty;
  logic           hs;
  logic           pop;
  logic [IDW-1:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    rr_sum    = '0;
    rr_winner = rr_ptr_q;
    rr_found  = 1'b0;
    for (int k = 0; k < MASTERS; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (rr_sum >= (IDW+1)'(MASTERS)) begin
        rr_sum = rr_sum - (IDW+1)'(MASTERS);
      end
      if (!rr_found && m_req_i[rr_sum[IDW-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = rr_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    winner  = rr_winner;
    win_req = rr_found;
    if (state_q == HOLD) begin
      winner  = held_id_q;
      win_req = m_req_i[held_id_q];
    end
  end

  assign fifo_full  = (cnt_q == CW'(OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  assign s_req_o = win_req && !fifo_full && !rst_i;
  assign hs      = s_req_o && s_gnt_i;
  assign pop     = s_rvalid_i && !fifo_empty && !rst_i;

  always_comb begin
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (win_req && winner == IDW'(i)) begin
        s_we_o    = m_we_i[i];
        s_be_o    = m_be_i[i*4 +: 4];
        s_addr_o  = m_addr_i[i*32 +: 32];
        s_wdata_o = m_wdata_i[i*32 +: 32];
      end
    end
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int i = 0; i < MASTERS; i++) begin
      m_gnt_o[i]    = hs && (winner == IDW'(i));
      m_rvalid_o[i] = pop && (head == IDW'(i));
    end
  end

  assign m_rdata_o = s_rdata_i;
  assign err_o     = err_q;

  // An offered but ungranted request locks the winner until handshake.
  always_comb begin
    state_d   = state_q;
    held_id_d = held_id_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (s_req_o && !s_gnt_i) begin
          state_d   = HOLD;
          held_id_d = winner;
        end
      end
      HOLD: begin
        if (hs || !m_req_i[held_id_q]) begin
          state_d = IDLE;
        end
      end
    endcase
    if (hs) begin
      rr_ptr_d = (winner == IDW'(MASTERS - 1)) ? '0 : winner + IDW'(1);
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (hs) begin
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (hs && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!hs && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
    err_d = s_rvalid_i && fifo_empty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      held_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      held_id_q <= held_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Scenario bench for obi_rr_arbiter: a queue of expected master IDs
// is filled on each expected grant and drained on each response.
module tb_obi_rr_arbiter;

  localparam int M = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [M-1:0]    m_req;
  logic [M-1:0]    m_gnt;
  logic [M-1:0]    m_we;
  logic [M*4-1:0]  m_be;
  logic [M*32-1:0] m_addr;
  logic [M*32-1:0] m_wdata;
  logic [M-1:0]    m_rvalid;
  logic [31:0]     m_rdata;
  logic            s_req;
  logic            s_gnt;
  logic            s_we;
  logic [3:0]      s_be;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic            s_rvalid;
  logic [31:0]     s_rdata;
  logic            err;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  obi_rr_arbiter #(.MASTERS(M), .OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_we_i(m_we), .m_be_i(m_be),
    .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_we_o(s_we), .s_be_o(s_be),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .err_o(err)
  );

  function automatic logic [31:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h0000_0100 + 32'h10;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_bus;
    for (int i = 0; i < M; i++) begin
      m_addr[i*32 +: 32]  = addr_of(i);
      m_wdata[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
      m_be[i*4 +: 4]      = 4'(i + 1);
      m_we[i]             = i[0];
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; m_req = '0; s_gnt = 1'b0;
    s_rvalid = 1'b0; s_rdata = '0;
    exp_q.delete();
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; m_req = 3'b111; s_gnt = 1'b1;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    tick;
    @(negedge clk);
    vectors++;
    if (s_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_s_req: got %b want 0", s_req);
    end
    vectors++;
    if (m_gnt !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_gnt: got %b want 000", m_gnt);
    end
    vectors++;
    if (m_rvalid !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_rvalid: got %b want 000", m_rvalid);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b want 0", err);
    end
    tick;
    rst = 1'b0; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || s_req !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got err=%b s_req=%b want 0 0", err, s_req);
    end
    tick;
  endtask

  task automatic test_round_robin;
    int seq[6] = '{0, 1, 2, 0, 1, 2};
    int e;
    do_reset;
    s_gnt = 1'b1;
    for (int c = 0; c < 7; c++) begin
      m_req    = (c < 6) ? 3'b111 : 3'b000;
      s_rvalid = (exp_q.size() > 0);
      s_rdata  = 32'hC0DE_0000 + 32'(c);
      @(negedge clk);
      if (c < 6) begin
        vectors++;
        if (m_gnt !== (3'b001 << seq[c])) begin
          miscompares++;
          $display("FAIL rr_gnt[%0d]: got %b want %b", c, m_gnt, 3'b001 << seq[c]);
        end
        vectors++;
        if (s_addr !== addr_of(seq[c])) begin
          miscompares++;
          $display("FAIL rr_addr[%0d]: got %h want %h", c, s_addr, addr_of(seq[c]));
        end
      end
      if (s_rvalid) begin
        e = exp_q.pop_front();
        vectors++;
        if (m_rvalid !== (3'b001 << e) || m_rdata !== s_rdata) begin
          miscompares++;
          $display("FAIL rr_resp[%0d]: got %b/%h want %b/%h", c, m_rvalid, m_rdata, 3'b001 << e, s_rdata);
        end
      end
      if (c < 6) exp_q.push_back(seq[c]);
      tick;
    end
    s_rvalid = 1'b0; s_gnt = 1'b0;
  endtask

  task automatic test_hold;
    int e;
    do_reset;
    s_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_req = (c == 0) ? 3'b010 : 3'b011;
      @(negedge clk);
      vectors++;
      if (s_req !== 1'b1 || s_addr !== addr_of(1) || m_gnt !== 3'b000) begin
        miscompares++;
        $display("FAIL hold[%0d]: got req=%b addr=%h gnt=%b want 1 %h 000", c, s_req, s_addr, m_gnt, addr_of(1));
      end
      tick;
    end
    s_gnt = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_gnt !== 3'b010) begin
      miscompares++;
      $display("FAIL hold_grant_m1: got %b want 010", m_gnt);
    end
    exp_q.push_back(1);
    tick;
    m_req = 3'b001;
    @(negedge clk);
    vectors++;
    if (m_gnt !== 3'b001 || s_addr !== addr_of(0)) begin
      miscompares++;
      $display("FAIL hold_grant_m0: got %b %h want 001 %h", m_gnt, s_addr, addr_of(0));
    end
    exp_q.push_back(0);
    tick;
    m_req = '0; s_gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s_rvalid = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (m_rvalid !== (3'b001 << e)) begin
        miscompares++;
        $display("FAIL hold_resp[%0d]: got %b want %b", c, m_rvalid, 3'b001 << e);
      end
      tick;
    end
    s_rvalid = 1'b0;
  endtask

  task automatic test_full;
    int e;
    do_reset;
    m_req = 3'b001; s_gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (m_gnt !== 3'b001) begin
        miscompares++;
        $display("FAIL full_fill[%0d]: got %b want 001", c, m_gnt);
      end
      exp_q.push_back(0);
      tick;
    end
    for (int c = 0; c < 2; c++) begin
      s_rvalid = (c == 1);
      @(negedge clk);
      vectors++;
      if (s_req !== 1'b0 || m_gnt !== 3'b000) begin
        miscompares++;
        $display("FAIL full_block[%0d]: got req=%b gnt=%b want 0 000", c, s_req, m_gnt);
      end
      if (s_rvalid) begin
        e = exp_q.pop_front();
        vectors++;
        if (m_rvalid !== (3'b001 << e)) begin
          miscompares++;
          $display("FAIL full_pop: got %b want %b", m_rvalid, 3'b001 << e);
        end
      end
      tick;
    end
    s_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_req !== 1'b1 || m_gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL full_resume: got req=%b gnt=%b want 1 001", s_req, m_gnt);
    end
    exp_q.push_back(0);
    tick;
    m_req = '0; s_gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s_rvalid = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (m_rvalid !== (3'b001 << e)) begin
        miscompares++;
        $display("FAIL full_drain[%0d]: got %b want %b", c, m_rvalid, 3'b001 << e);
      end
      tick;
    end
    s_rvalid = 1'b0;
  endtask

  task automatic test_resp_data;
    logic [31:0] dat[2] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A};
    int e;
    do_reset;
    s_gnt = 1'b1; m_req = 3'b100;
    @(negedge clk);
    vectors++;
    if (m_gnt !== 3'b100) begin
      miscompares++;
      $display("FAIL data_grant_m2: got %b want 100", m_gnt);
    end
    exp_q.push_back(2);
    tick;
    m_req = 3'b001;
    @(negedge clk);
    vectors++;
    if (m_gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL data_grant_m0: got %b want 001", m_gnt);
    end
    exp_q.push_back(0);
    tick;
    m_req = '0; s_gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s_rvalid = 1'b1; s_rdata = dat[c];
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (m_rvalid !== (3'b001 << e) || m_rdata !== dat[c]) begin
        miscompares++;
        $display("FAIL data_resp[%0d]: got %b/%h want %b/%h", c, m_rvalid, m_rdata, 3'b001 << e, dat[c]);
      end
      tick;
    end
    s_rvalid = 1'b0;
  endtask

  task automatic test_err;
    do_reset;
    s_rvalid = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_rvalid !== 3'b000 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cycle0: got rvalid=%b err=%b want 000 0", m_rvalid, err);
    end
    tick;
    s_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_pulse: got %b want 1", err);
    end
    tick;
    @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int e;
    do_reset;
    s_gnt = 1'b1; m_req = 3'b010;
    @(negedge clk);
    vectors++;
    if (m_gnt !== 3'b010) begin
      miscompares++;
      $display("FAIL rmid_grant_m1: got %b want 010", m_gnt);
    end
    tick;
    s_gnt = 1'b0; m_req = 3'b100;
    @(negedge clk);
    vectors++;
    if (s_req !== 1'b1 || s_addr !== addr_of(2)) begin
      miscompares++;
      $display("FAIL rmid_hold: got req=%b addr=%h want 1 %h", s_req, s_addr, addr_of(2));
    end
    tick;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_req !== 1'b0 || m_gnt !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_in_reset: got req=%b gnt=%b want 0 000", s_req, m_gnt);
    end
    tick;
    rst = 1'b0;
    exp_q.delete();
    m_req = 3'b111;
    @(negedge clk);
    vectors++;
    if (s_req !== 1'b1 || s_addr !== addr_of(0)) begin
      miscompares++;
      $display("FAIL rmid_restart: got req=%b addr=%h want 1 %h", s_req, s_addr, addr_of(0));
    end
    tick;
    s_gnt = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_gnt !== 3'b001) begin
      miscompares++;
      $display("FAIL rmid_grant_m0: got %b want 001", m_gnt);
    end
    exp_q.push_back(0);
    tick;
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (m_rvalid !== (3'b001 << e)) begin
      miscompares++;
      $display("FAIL rmid_resp: got %b want %b", m_rvalid, 3'b001 << e);
    end
    tick;
    @(negedge clk);
    vectors++;
    if (m_rvalid !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_discard: got %b want 000", m_rvalid);
    end
    tick;
    s_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_err: got %b want 1", err);
    end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; m_req = '0; s_gnt = 1'b0;
    s_rvalid = 1'b0; s_rdata = '0;
    m_addr = '0; m_wdata = '0; m_be = '0; m_we = '0;
    init_bus;
    test_reset;
    test_round_robin;
    test_hold;
    test_full;
    test_resp_data;
    test_err;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
